msrv32_wb_sequencer: RTL and testbench

// - Write-back stage consumer of the stage-2 pipeline registers. Selects the write-back

---
 rtl/msrv32_wb_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_msrv32_wb_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_wb_sequencer.sv
// ----------------------------------------------------------------------------
// msrv32_wb_sequencer
//
// Write-back stage behind the stage-2 pipeline registers. This module:
//   - selects the write-back source (ALU, load, immediate, address adder,
//     CSR or PC+4),
//   - aligns and sign- or zero-extends load data from the data bus,
//   - sequences register-file writes,
//   - stalls upstream while a load data phase is outstanding.
//
// Optional feature: define LOAD_TIMEOUT_EN to bound the load data phase.
// After TIMEOUT_CYCLES wait-state cycles the load is abandoned and
// bus_error_out pulses. With the macro undefined, bus_error_out is tied to 0
// and a load waits indefinitely.
//
// Ports
//   clk_in, reset_in            clock (rising edge), async active-high reset
//   valid_in                    stage-2 registers hold a live instruction
//   rd_addr_reg_in              destination register
//   rf_wr_en_reg_in             instruction writes rd
//   wb_mux_sel_reg_in           0 ALU, 1 LOAD, 2 IMM, 3 IADDER, 4 CSR,
//                               5 PC+4; 6-7 behave as ALU
//   load_size_reg_in            00 byte, 01 half, 1x word
//   load_unsigned_reg_in        1 = zero-extend, 0 = sign-extend
//   alu_result_in, imm_reg_in, iadder_out_reg_in, pc_plus_4_reg_in,
//   csr_data_in                 write-back sources
//                               (iadder_out_reg_in[1:0] is the load byte offset)
//   dmdata_in, hready_in        data-bus read data and ready
//   rf_wr_en_out                register-file write strobe (1-cycle pulse)
//   rd_addr_out, rd_data_out    register-file write address and data
//   stall_out                   hold stage-2 registers
//   load_misaligned_out         1-cycle pulse on a misaligned load
//   bus_error_out               1-cycle pulse on a load timeout
// ----------------------------------------------------------------------------
module msrv32_wb_sequencer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        valid_in,
    input  logic [4:0]  rd_addr_reg_in,
    input  logic        rf_wr_en_reg_in,
    input  logic [2:0]  wb_mux_sel_reg_in,
    input  logic [1:0]  load_size_reg_in,
    input  logic        load_unsigned_reg_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] imm_reg_in,
    input  logic [31:0] iadder_out_reg_in,
    input  logic [31:0] pc_plus_4_reg_in,
    input  logic [31:0] csr_data_in,
    input  logic [31:0] dmdata_in,
    input  logic        hready_in,
    output logic        rf_wr_en_out,
    output logic [4:0]  rd_addr_out,
    output logic [31:0] rd_data_out,
    output logic        stall_out,
    output logic        load_misaligned_out,
    output logic        bus_error_out
);

    // state     | meaning
    // IDLE      | accepting instructions; non-loads are written back directly
    // LOAD_WAIT | load data phase outstanding; upstream is stalled
    typedef enum logic {IDLE, LOAD_WAIT} state_t;

    state_t      state;
    logic [4:0]  cap_rd;
    logic        cap_wr;
    logic [1:0]  cap_size;
    logic        cap_uns;
    logic [1:0]  cap_off;

    logic        is_load;
    logic        misaligned;
    logic [31:0] wb_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

`ifdef LOAD_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tcnt;
    logic       bus_err;
    assign bus_error_out = bus_err;
`else
    assign bus_error_out = 1'b0;
`endif

    assign stall_out = (state == LOAD_WAIT);
    assign is_load   = (wb_mux_sel_reg_in == 3'd1);

    // Size 1x is a word access, so any non-zero offset is misaligned.
    assign misaligned = ((load_size_reg_in == 2'b01) & iadder_out_reg_in[0]) |
                        (load_size_reg_in[1] & (iadder_out_reg_in[1:0] != 2'b00));

    always_comb begin
        wb_data = alu_result_in;
        case (wb_mux_sel_reg_in)
            3'd2:    wb_data = imm_reg_in;
            3'd3:    wb_data = iadder_out_reg_in;
            3'd4:    wb_data = csr_data_in;
            3'd5:    wb_data = pc_plus_4_reg_in;
            default: wb_data = alu_result_in;
        endcase
    end

    always_comb begin
        byte_sel = dmdata_in[7:0];
        case (cap_off)
            2'd1:    byte_sel = dmdata_in[15:8];
            2'd2:    byte_sel = dmdata_in[23:16];
            2'd3:    byte_sel = dmdata_in[31:24];
            default: byte_sel = dmdata_in[7:0];
        endcase
        half_sel  = cap_off[1] ? dmdata_in[31:16] : dmdata_in[15:0];
        load_data = dmdata_in;
        case (cap_size)
            2'b00:   load_data = cap_uns ? {24'h0, byte_sel}
                                         : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_data = cap_uns ? {16'h0, half_sel}
                                         : {{16{half_sel[15]}}, half_sel};
            default: load_data = dmdata_in;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state               <= IDLE;
            cap_rd              <= 5'd0;
            cap_wr              <= 1'b0;
            cap_size            <= 2'd0;
            cap_uns             <= 1'b0;
            cap_off             <= 2'd0;
            rf_wr_en_out        <= 1'b0;
            rd_addr_out         <= 5'd0;
            rd_data_out         <= 32'd0;
            load_misaligned_out <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
            tcnt                <= 8'd0;
            bus_err             <= 1'b0;
`endif
        end else begin
            rf_wr_en_out        <= 1'b0;
            load_misaligned_out <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
            bus_err             <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        if (is_load) begin
                            if (misaligned) begin
                                load_misaligned_out <= 1'b1;
                            end else begin
                                state    <= LOAD_WAIT;
                                cap_rd   <= rd_addr_reg_in;
                                cap_wr   <= rf_wr_en_reg_in;
                                cap_size <= load_size_reg_in;
                                cap_uns  <= load_unsigned_reg_in;
                                cap_off  <= iadder_out_reg_in[1:0];
`ifdef LOAD_TIMEOUT_EN
                                tcnt     <= 8'd0;
`endif
                            end
                        end else begin
                            rf_wr_en_out <= rf_wr_en_reg_in & (rd_addr_reg_in != 5'd0);
                            rd_addr_out  <= rd_addr_reg_in;
                            rd_data_out  <= wb_data;
                        end
                    end
                end
                LOAD_WAIT: begin
                    // valid_in is ignored here; upstream holds the next
                    // instruction until stall_out drops.
                    if (hready_in) begin
                        state        <= IDLE;
                        rf_wr_en_out <= cap_wr & (cap_rd != 5'd0);
                        rd_addr_out  <= cap_rd;
                        rd_data_out  <= load_data;
                    end
`ifdef LOAD_TIMEOUT_EN
                    else if (tcnt == TIMEOUT_LAST) begin
                        state   <= IDLE;
                        bus_err <= 1'b1;
                        tcnt    <= 8'd0;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msrv32_wb_sequencer.sv
module tb_msrv32_wb_sequencer;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        valid_in;
    logic [4:0]  rd_addr_reg_in;
    logic        rf_wr_en_reg_in;
    logic [2:0]  wb_mux_sel_reg_in;
    logic [1:0]  load_size_reg_in;
    logic        load_unsigned_reg_in;
    logic [31:0] alu_result_in;
    logic [31:0] imm_reg_in;
    logic [31:0] iadder_out_reg_in;
    logic [31:0] pc_plus_4_reg_in;
    logic [31:0] csr_data_in;
    logic [31:0] dmdata_in;
    logic        hready_in;
    logic        rf_wr_en_out;
    logic [4:0]  rd_addr_out;
    logic [31:0] rd_data_out;
    logic        stall_out;
    logic        load_misaligned_out;
    logic        bus_error_out;

    int nvec = 0;
    int nerr = 0;

    msrv32_wb_sequencer #(.TIMEOUT_CYCLES(4)) dut (
        .clk_in               (clk_in),
        .reset_in             (reset_in),
        .valid_in             (valid_in),
        .rd_addr_reg_in       (rd_addr_reg_in),
        .rf_wr_en_reg_in      (rf_wr_en_reg_in),
        .wb_mux_sel_reg_in    (wb_mux_sel_reg_in),
        .load_size_reg_in     (load_size_reg_in),
        .load_unsigned_reg_in (load_unsigned_reg_in),
        .alu_result_in        (alu_result_in),
        .imm_reg_in           (imm_reg_in),
        .iadder_out_reg_in    (iadder_out_reg_in),
        .pc_plus_4_reg_in     (pc_plus_4_reg_in),
        .csr_data_in          (csr_data_in),
        .dmdata_in            (dmdata_in),
        .hready_in            (hready_in),
        .rf_wr_en_out         (rf_wr_en_out),
        .rd_addr_out          (rd_addr_out),
        .rd_data_out          (rd_data_out),
        .stall_out            (stall_out),
        .load_misaligned_out  (load_misaligned_out),
        .bus_error_out        (bus_error_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic issue(input logic [2:0] sel, input logic [4:0] rd, input logic wr,
                         input logic [1:0] size, input logic uns, input logic [31:0] addr);
        valid_in             = 1'b1;
        wb_mux_sel_reg_in    = sel;
        rd_addr_reg_in       = rd;
        rf_wr_en_reg_in      = wr;
        load_size_reg_in     = size;
        load_unsigned_reg_in = uns;
        iadder_out_reg_in    = addr;
    endtask

    task automatic chk_write(input string tag, input logic we, input logic [4:0] rd,
                             input logic [31:0] data);
        chk({tag, "_we"},    {31'd0, rf_wr_en_out}, {31'd0, we});
        chk({tag, "_rd"},    {27'd0, rd_addr_out},  {27'd0, rd});
        chk({tag, "_data"},  rd_data_out,           data);
        chk({tag, "_stall"}, {31'd0, stall_out},    32'd0);
    endtask

    initial begin
        reset_in = 1'b1;
        valid_in = 1'b0; rd_addr_reg_in = 5'd0; rf_wr_en_reg_in = 1'b0;
        wb_mux_sel_reg_in = 3'd0; load_size_reg_in = 2'd0; load_unsigned_reg_in = 1'b0;
        alu_result_in = 32'h1234_5678; imm_reg_in = 32'hABCD_E000;
        iadder_out_reg_in = 32'h0; pc_plus_4_reg_in = 32'h104;
        csr_data_in = 32'hC5C5_0001; dmdata_in = 32'h0; hready_in = 1'b0;
        step(); step();
        reset_in = 1'b0;
        chk("rst_we",   {31'd0, rf_wr_en_out}, 32'd0);
        chk("rst_rd",   {27'd0, rd_addr_out},  32'd0);
        chk("rst_data", rd_data_out, 32'd0);
        chk("rst_stall", {31'd0, stall_out}, 32'd0);
        chk("rst_mis",  {31'd0, load_misaligned_out}, 32'd0);
        chk("rst_berr", {31'd0, bus_error_out}, 32'd0);

        // ALU write, then the strobe drops
        issue(3'd0, 5'd5, 1'b1, 2'd0, 1'b0, 32'h0);
        step();
        chk_write("alu", 1'b1, 5'd5, 32'h1234_5678);
        valid_in = 1'b0;
        step();
        chk("alu_pulse", {31'd0, rf_wr_en_out}, 32'd0);

        // LB signed, offset 2, three wait states
        issue(3'd1, 5'd7, 1'b1, 2'b00, 1'b0, 32'h0000_1002);
        dmdata_in = 32'h0080_0000;
        hready_in = 1'b0;
        step();
        valid_in = 1'b0;
        chk("lb_stall0", {31'd0, stall_out}, 32'd1);
        for (int i = 1; i < 4; i++) begin
            step();
            chk($sformatf("lb_stall%0d", i), {31'd0, stall_out}, 32'd1);
            chk($sformatf("lb_nowe%0d", i), {31'd0, rf_wr_en_out}, 32'd0);
        end
        hready_in = 1'b1;
        step();
        chk_write("lb", 1'b1, 5'd7, 32'hFFFF_FF80);
        hready_in = 1'b0;
        step();
        chk("lb_pulse", {31'd0, rf_wr_en_out}, 32'd0);

        // LHU offset 2 (upper half, zero-extended), zero wait states
        issue(3'd1, 5'd8, 1'b1, 2'b01, 1'b1, 32'h0000_2002);
        dmdata_in = 32'h8765_4321;
        hready_in = 1'b1;
        step();
        valid_in = 1'b0;
        chk("lhu_stall", {31'd0, stall_out}, 32'd1);
        step();
        chk_write("lhu", 1'b1, 5'd8, 32'h0000_8765);

        // LH signed offset 0, LB unsigned offset 3, LW
        issue(3'd1, 5'd9, 1'b1, 2'b01, 1'b0, 32'h0000_2000);
        dmdata_in = 32'h0000_9ABC;
        step(); valid_in = 1'b0; step();
        chk_write("lh", 1'b1, 5'd9, 32'hFFFF_9ABC);
        issue(3'd1, 5'd10, 1'b1, 2'b00, 1'b1, 32'h0000_2003);
        dmdata_in = 32'hF100_0000;
        step(); valid_in = 1'b0; step();
        chk_write("lbu", 1'b1, 5'd10, 32'h0000_00F1);
        issue(3'd1, 5'd11, 1'b1, 2'b10, 1'b0, 32'h0000_2004);
        dmdata_in = 32'hDEAD_BEEF;
        step(); valid_in = 1'b0; step();
        chk_write("lw", 1'b1, 5'd11, 32'hDEAD_BEEF);
        hready_in = 1'b0;

        // LHU offset 1: misaligned
        issue(3'd1, 5'd12, 1'b1, 2'b01, 1'b1, 32'h0000_3001);
        step();
        valid_in = 1'b0;
        chk("lhu_mis",   {31'd0, load_misaligned_out}, 32'd1);
        chk("lhu_mis_we", {31'd0, rf_wr_en_out}, 32'd0);
        chk("lhu_mis_stall", {31'd0, stall_out}, 32'd0);
        step();
        chk("lhu_mis_pulse", {31'd0, load_misaligned_out}, 32'd0);
        chk("lhu_mis_stall2", {31'd0, stall_out}, 32'd0);

        // LW offset 2: misaligned
        issue(3'd1, 5'd12, 1'b1, 2'b10, 1'b0, 32'h0000_3002);
        step();
        valid_in = 1'b0;
        chk("lw_mis", {31'd0, load_misaligned_out}, 32'd1);
        chk("lw_mis_stall", {31'd0, stall_out}, 32'd0);

        // JAL to x0: no strobe but address/data still update; then LUI
        issue(3'd5, 5'd0, 1'b1, 2'd0, 1'b0, 32'h0);
        step();
        chk_write("jal_x0", 1'b0, 5'd0, 32'h0000_0104);
        issue(3'd2, 5'd3, 1'b1, 2'd0, 1'b0, 32'h0);
        step();
        chk_write("lui", 1'b1, 5'd3, 32'hABCD_E000);

        // Remaining sources: IADDER, CSR, sel 7 as ALU, rf_wr_en=0
        issue(3'd3, 5'd4, 1'b1, 2'd0, 1'b0, 32'h0000_5550);
        step();
        chk_write("iadder", 1'b1, 5'd4, 32'h0000_5550);
        issue(3'd4, 5'd6, 1'b1, 2'd0, 1'b0, 32'h0);
        step();
        chk_write("csr", 1'b1, 5'd6, 32'hC5C5_0001);
        issue(3'd7, 5'd13, 1'b1, 2'd0, 1'b0, 32'h0);
        step();
        chk_write("sel7", 1'b1, 5'd13, 32'h1234_5678);
        issue(3'd0, 5'd14, 1'b0, 2'd0, 1'b0, 32'h0);
        alu_result_in = 32'h0000_0077;
        step();
        chk_write("nowr", 1'b0, 5'd14, 32'h0000_0077);

        // Load completes while next instruction is already valid: load wins
        issue(3'd1, 5'd15, 1'b1, 2'b10, 1'b0, 32'h0000_4000);
        dmdata_in = 32'h0BAD_F00D;
        hready_in = 1'b0;
        step();
        issue(3'd0, 5'd16, 1'b1, 2'd0, 1'b0, 32'h0);
        alu_result_in = 32'h0000_0055;
        chk("ovl_stall", {31'd0, stall_out}, 32'd1);
        step();
        chk("ovl_hold_we", {31'd0, rf_wr_en_out}, 32'd0);
        hready_in = 1'b1;
        step();
        chk_write("ovl_load", 1'b1, 5'd15, 32'h0BAD_F00D);
        hready_in = 1'b0;
        step();
        valid_in = 1'b0;
        chk_write("ovl_alu", 1'b1, 5'd16, 32'h0000_0055);

        // Reset in LOAD_WAIT: outputs clear at once, load abandoned
        issue(3'd1, 5'd17, 1'b1, 2'b10, 1'b0, 32'h0);
        step();
        valid_in = 1'b0;
        chk("rstw_stall_pre", {31'd0, stall_out}, 32'd1);
        #2 reset_in = 1'b1;
        #1;
        chk("rstw_stall", {31'd0, stall_out}, 32'd0);
        chk("rstw_rd",    {27'd0, rd_addr_out}, 32'd0);
        chk("rstw_data",  rd_data_out, 32'd0);
        chk("rstw_we",    {31'd0, rf_wr_en_out}, 32'd0);
        step();
        reset_in  = 1'b0;
        hready_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rstw_nowe%0d", i), {31'd0, rf_wr_en_out}, 32'd0);
            chk($sformatf("rstw_idle%0d", i), {31'd0, stall_out}, 32'd0);
        end
        hready_in = 1'b0;

        // Load with hready held low
        issue(3'd1, 5'd18, 1'b1, 2'b10, 1'b0, 32'h0);
        step();
        valid_in = 1'b0;
`ifdef LOAD_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_stall%0d", i), {31'd0, stall_out}, 32'd1);
            chk($sformatf("to_berr%0d", i),  {31'd0, bus_error_out}, 32'd0);
            step();
        end
        chk("to_berr",   {31'd0, bus_error_out}, 32'd1);
        chk("to_stall",  {31'd0, stall_out}, 32'd0);
        chk("to_we",     {31'd0, rf_wr_en_out}, 32'd0);
        step();
        chk("to_berr_pulse", {31'd0, bus_error_out}, 32'd0);
`else
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("wait_stall%0d", i), {31'd0, stall_out}, 32'd1);
            chk($sformatf("wait_berr%0d", i),  {31'd0, bus_error_out}, 32'd0);
            step();
        end
        hready_in = 1'b1;
        dmdata_in = 32'h1357_9BDF;
        step();
        chk_write("wait_done", 1'b1, 5'd18, 32'h1357_9BDF);
        hready_in = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
